// File: rtl/square_arbiter_pkg.sv
// Shared fixed-point helpers for the square_arbiter slice.
package square_arbiter_pkg;

  localparam int FRAC_BITS_DEFAULT = 10;
  localparam int DEQ_W             = 128;

  // Divide by 2**frac_bits, rounding toward zero (bias negatives before the shift).
  function automatic logic signed [DEQ_W-1:0] dequantize(
    input logic signed [DEQ_W-1:0] value,
    input int                      frac_bits
  );
    logic signed [DEQ_W-1:0] bias;
    bias = '0;
    if (value[DEQ_W-1]) bias = (DEQ_W'(1) <<< frac_bits) - DEQ_W'(1);
    return (value + bias) >>> frac_bits;
  endfunction

endpackage

// File: rtl/square_rr_grant.sv
// Two-way round-robin grant: prio only breaks ties when both channels are eligible.
module square_rr_grant (
  input  logic [1:0] elig,
  input  logic       prio,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |elig;
    grant_id    = (&elig) ? prio : elig[1];
  end

endmodule

// File: rtl/square_arbiter.sv
// Shares one squaring datapath between two FIFO streams, granting in round-robin order
// and returning each dequantized square to the granted channel's own output FIFO.
module square_arbiter
  import square_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 in0_rd_en,
  input  logic                 in0_empty,
  input  logic [DATA_SIZE-1:0] in0_din,
  output logic                 in1_rd_en,
  input  logic                 in1_empty,
  input  logic [DATA_SIZE-1:0] in1_din,
  output logic                 out0_wr_en,
  input  logic                 out0_full,
  output logic [DATA_SIZE-1:0] out0_dout,
  output logic                 out1_wr_en,
  input  logic                 out1_full,
  output logic [DATA_SIZE-1:0] out1_dout,
  output logic                 busy
);

  localparam int PROD_W = 2 * DATA_SIZE;

  // One-hot encoding leaves spare codes that fall back to ARB.
  typedef enum logic [1:0] {
    ARB   = 2'b01,
    WRITE = 2'b10
  } state_t;

  state_t                    state, state_next;
  logic                      prio, owner;
  logic signed [PROD_W-1:0]  product;
  logic signed [PROD_W-1:0]  din0_ext, din1_ext, square0, square1;
  logic [1:0]                elig;
  logic                      grant_valid, grant_id;
  logic                      owner_full;
  logic [DATA_SIZE-1:0]      result;

  assign din0_ext   = PROD_W'($signed(in0_din));
  assign din1_ext   = PROD_W'($signed(in1_din));
  assign square0    = din0_ext * din0_ext;
  assign square1    = din1_ext * din1_ext;
  // A full output only masks its own channel, so the other one keeps flowing.
  assign elig       = {!in1_empty && !out1_full, !in0_empty && !out0_full};
  assign owner_full = owner ? out1_full : out0_full;
  assign result     = DATA_SIZE'(dequantize(DEQ_W'(product), FRAC_BITS));

  square_rr_grant u_grant (
    .elig        (elig),
    .prio        (prio),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ARB;
      prio    <= 1'b0;
      owner   <= 1'b0;
      product <= '0;
    end else begin
      state <= state_next;
      if (state == ARB && grant_valid) begin
        owner   <= grant_id;
        product <= grant_id ? square1 : square0;
      end
      if (state == WRITE && !owner_full) prio <= ~owner;
    end
  end

  always_comb begin
    state_next = state;
    in0_rd_en  = 1'b0;
    in1_rd_en  = 1'b0;
    out0_wr_en = 1'b0;
    out1_wr_en = 1'b0;
    out0_dout  = '0;
    out1_dout  = '0;
    busy       = 1'b0;
    case (state)
      ARB: begin
        if (grant_valid) begin
          state_next = WRITE;
          in0_rd_en  = !grant_id;
          in1_rd_en  = grant_id;
        end
      end
      WRITE: begin
        busy = 1'b1;
        if (owner) out1_dout = result;
        else       out0_dout = result;
        if (!owner_full) begin
          out0_wr_en = !owner;
          out1_wr_en = owner;
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
    // Outputs are quiet for the whole reset cycle, not only after it.
    if (reset) begin
      in0_rd_en  = 1'b0;
      in1_rd_en  = 1'b0;
      out0_wr_en = 1'b0;
      out1_wr_en = 1'b0;
      out0_dout  = '0;
      out1_dout  = '0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_square_arbiter.sv
// Self-checking bench for square_arbiter: FIFO queues plus a transaction-level reference model.
module tb_square_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        in0_rd_en, in1_rd_en, out0_wr_en, out1_wr_en, busy;
  logic        in0_empty, in1_empty, out0_full, out1_full;
  logic [31:0] in0_din, in1_din, out0_dout, out1_dout;

  square_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .in0_rd_en  (in0_rd_en),
    .in0_empty  (in0_empty),
    .in0_din    (in0_din),
    .in1_rd_en  (in1_rd_en),
    .in1_empty  (in1_empty),
    .in1_din    (in1_din),
    .out0_wr_en (out0_wr_en),
    .out0_full  (out0_full),
    .out0_dout  (out0_dout),
    .out1_wr_en (out1_wr_en),
    .out1_full  (out1_full),
    .out1_dout  (out1_dout),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus FIFOs and controls
  int in0_q[$];
  int in1_q[$];
  bit full0 = 1'b0, full1 = 1'b0, rst = 1'b1;

  // Reference model: a held result (if any), who owns it, and whose turn a tie is.
  bit m_held  = 1'b0;
  bit m_owner = 1'b0;
  bit m_prio  = 1'b0;
  int m_value = 0;

  // Writes seen at the DUT outputs
  int log_ch[$];
  int log_val[$];

  function automatic int deq_square(input int d);
    longint p;
    p = longint'(d) * longint'(d);
    return int'(p / 1024);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          e_r0, e_r1, e_w0, e_w1, e_b, el0, el1, g;
    logic [31:0] e_d0, e_d1;
    int          d;
    reset     = rst;
    in0_empty = (in0_q.size() == 0);
    in1_empty = (in1_q.size() == 0);
    in0_din   = in0_empty ? 32'h0 : in0_q[0];
    in1_din   = in1_empty ? 32'h0 : in1_q[0];
    out0_full = full0;
    out1_full = full1;
    @(negedge clock);
    {e_r0, e_r1, e_w0, e_w1, e_b} = '0;
    e_d0 = '0;
    e_d1 = '0;
    if (rst) begin
      m_held = 1'b0;
      m_prio = 1'b0;
    end else if (!m_held) begin
      el0 = !in0_empty && !full0;
      el1 = !in1_empty && !full1;
      if (el0 || el1) begin
        g = (el0 && el1) ? m_prio : el1;
        if (g) begin e_r1 = 1'b1; d = in1_q.pop_front(); end
        else   begin e_r0 = 1'b1; d = in0_q.pop_front(); end
        m_held  = 1'b1;
        m_owner = g;
        m_value = deq_square(d);
      end
    end else begin
      e_b = 1'b1;
      if (m_owner) e_d1 = m_value; else e_d0 = m_value;
      if (!(m_owner ? full1 : full0)) begin
        if (m_owner) e_w1 = 1'b1; else e_w0 = 1'b1;
        m_prio = !m_owner;
        m_held = 1'b0;
      end
    end
    check("in0_rd_en",  in0_rd_en,  e_r0);
    check("in1_rd_en",  in1_rd_en,  e_r1);
    check("out0_wr_en", out0_wr_en, e_w0);
    check("out1_wr_en", out1_wr_en, e_w1);
    check("out0_dout",  out0_dout,  e_d0);
    check("out1_dout",  out1_dout,  e_d1);
    check("busy",       busy,       e_b);
    if (out0_wr_en === 1'b1) begin log_ch.push_back(0); log_val.push_back(out0_dout); end
    if (out1_wr_en === 1'b1) begin log_ch.push_back(1); log_val.push_back(out1_dout); end
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    in0_q.delete();
    in1_q.delete();
    full0 = 1'b0;
    full1 = 1'b0;
    rst   = 1'b1;
    run(2);
    rst   = 1'b0;
  endtask

  int s, n1;

  initial begin
    reset     = 1'b1;
    in0_empty = 1'b1;
    in1_empty = 1'b1;
    in0_din   = '0;
    in1_din   = '0;
    out0_full = 1'b0;
    out1_full = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    // Single sample on channel 0
    s = log_ch.size();
    in0_q.push_back(1536);
    run(4);
    check("s1_count", log_ch.size() - s, 1);
    check("s1_ch",    log_ch[s],  0);
    check("s1_val",   log_val[s], 2304);

    // Dual demand alternates starting with channel 0
    do_reset();
    s = log_ch.size();
    in0_q = '{-1536, 100};
    in1_q = '{512, -1};
    run(10);
    check("s2_count", log_ch.size() - s, 4);
    check("s2_ch0",  log_ch[s],     0); check("s2_val0", log_val[s],     2304);
    check("s2_ch1",  log_ch[s + 1], 1); check("s2_val1", log_val[s + 1], 256);
    check("s2_ch2",  log_ch[s + 2], 0); check("s2_val2", log_val[s + 2], 9);
    check("s2_ch3",  log_ch[s + 3], 1); check("s2_val3", log_val[s + 3], 0);

    // Blocked output on ch0: ch1 keeps flowing, ch0 keeps its priority
    do_reset();
    full0 = 1'b1;
    in0_q = '{300, 400};
    in1_q = '{7, 8, 9};
    s = log_ch.size();
    run(8);
    check("s3_in0_left", in0_q.size(), 2);
    check("s3_count", log_ch.size() - s, 3);
    full0 = 1'b0;
    in1_q.push_back(10);
    s = log_ch.size();
    run(4);
    check("s3_next_ch",  log_ch[s],  0);
    check("s3_next_val", log_val[s], 87);
    run(6);

    // Output stall on ch1 while holding a result
    do_reset();
    in1_q.push_back(2048);
    run(1);
    full1 = 1'b1;
    in0_q.push_back(5);
    s = log_ch.size();
    run(5);
    check("s4_stall_writes", log_ch.size() - s, 0);
    check("s4_in0_kept",     in0_q.size(), 1);
    full1 = 1'b0;
    run(1);
    check("s4_count", log_ch.size() - s, 1);
    check("s4_val",   log_val[s], 4096);
    run(3);

    // Reset while holding a result discards it
    do_reset();
    in1_q.push_back(2048);
    run(1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    s = log_ch.size();
    in0_q.push_back(3);
    in1_q.push_back(4);
    run(6);
    check("s5_count",   log_ch.size() - s, 2);
    check("s5_first",   log_ch[s], 0);
    check("s5_second",  log_val[s + 1], 0);

    // Largest magnitude samples truncate to zero
    do_reset();
    in0_q.push_back(int'(32'h8000_0000));
    in1_q.push_back(int'(32'h8000_0000));
    s = log_ch.size();
    run(6);
    check("s6_count", log_ch.size() - s, 2);
    check("s6_val0",  log_val[s],     0);
    check("s6_val1",  log_val[s + 1], 0);

    // Random traffic, backpressure and occasional reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (in0_q.size() < 4 && $urandom_range(0, 2) == 0) in0_q.push_back(int'($urandom));
      if (in1_q.size() < 4 && $urandom_range(0, 2) == 0) in1_q.push_back(int'($urandom_range(0, 65535)) - 32768);
      full0 = ($urandom_range(0, 3) == 0);
      full1 = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;
    full0 = 1'b0;
    full1 = 1'b0;
    run(20);
    n1 = in0_q.size() + in1_q.size();
    check("rand_drained", n1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
